lsu_bus_ctrl: RTL and testbench
===============================

// Module: lsu_bus_ctrl
// PURPOSE
//  Load/store unit between the execute datapath and the data bus. Takes the datapath's data address/store
//  data plus lw/lb/sw decode, runs one bus transaction with req/ack handshake, returns load data to the
//  datapath's data-in, and holds o_busy high to stall execute (gate i_exec_ce) until the access retires.
//  Detects misaligned words, bus errors and bus timeouts; only one access is in flight at a time.
// PARAMETERS
//  AW        16   address width (byte address)
//  DW        16   data width; fixed at 16 (two byte lanes)
//  TIMEOUT   255  max cycles in REQ without ack before abort; 8-bit counter; 0 disables timeout
// PORTS
//  i_clk          in   1   clock
//  i_rst          in   1   reset, synchronous, active-high
//  i_req_valid    in   1   execute stage holds a memory instruction (level; held while o_busy)
//  i_is_lw        in   1   load word
//  i_is_lb        in   1   load byte, zero-extended
//  i_is_sw        in   1   store word
//  i_addr         in   AW  byte address from datapath
//  i_wdata        in   DW  store data from datapath
//  o_busy         out  1   stall execute; combinational
//  o_rdata        out  DW  load result to datapath data-in; registered, held until next load completes
//  o_rdata_valid  out  1   one-cycle pulse: the access retires this cycle
//  o_err          out  1   one-cycle pulse: misaligned, illegal decode, bus error or timeout
//  o_err_cause    out  2   01 misaligned/illegal, 10 bus error, 11 timeout; held until next error
//  o_bus_req      out  1   bus request; registered
//  o_bus_we       out  1   1 = write
//  o_bus_addr     out  AW  registered address; bit0 forced 0 for lw/sw
//  o_bus_wdata    out  DW  registered store data
//  o_bus_be       out  2   byte enables: lw/sw 11; lb 01 when addr[0]=0, 10 when addr[0]=1
//  i_bus_ack      in   1   slave completes transfer (single-cycle pulse expected)
//  i_bus_rdata    in   DW  read data, valid with i_bus_ack
//  i_bus_err      in   1   slave error, sampled with or without ack
// BEHAVIOUR
//  Reset: state IDLE; o_bus_req/o_bus_we/o_rdata_valid/o_err 0; o_bus_addr/o_bus_wdata/o_rdata 0;
//   o_bus_be 00; o_err_cause 00; timeout counter 0. Reset mid-access drops o_bus_req at the next edge.
//  States: IDLE, REQ, DONE, ERR.
//  IDLE: accept when i_req_valid and exactly one of lw/lb/sw is set.
//   Illegal (zero or more than one set) or lw/sw with i_addr[0]=1 -> ERR, no bus cycle, cause 01.
//   Otherwise latch addr/wdata/be/we, assert o_bus_req, counter 0 -> REQ.
//  REQ: o_bus_req held high, all bus outputs stable. Counter increments each cycle.
//   i_bus_err=1 -> ERR, cause 10; error has priority over ack in the same cycle.
//   i_bus_ack=1 -> drop o_bus_req. For a load, latch o_rdata: lw = i_bus_rdata; lb = {8'h00, selected lane}.
//    Then -> DONE. A store leaves o_rdata unchanged.
//   Counter reaches TIMEOUT with no ack -> drop o_bus_req -> ERR, cause 11. An ack in that same cycle
//    wins (normal completion).
//  DONE: o_rdata_valid=1 for one cycle, o_busy=0 so execute retires; i_req_valid ignored this cycle,
//   preventing re-issue of the retiring instruction -> IDLE.
//  ERR: o_err=1 for one cycle, o_busy=0 (instruction retires; control raises a trap); o_rdata unchanged;
//   i_req_valid ignored -> IDLE.
//  o_busy = (state==IDLE & i_req_valid) | (state==REQ).
//  Latency: request seen in cycle 0, o_bus_req from cycle 1. Ack in cycle k gives DONE in cycle k+1.
//   Minimum load/store is 3 cycles (ack in cycle 1).
//  Back-to-back: a new request is accepted in IDLE the cycle after DONE/ERR; no bubble-free issue.
//  i_bus_ack/i_bus_err outside REQ are ignored.
// TESTING
//  lw addr=0x0040, ack in cycle 1 with rdata=0xBEEF -> be=11, we=0; o_rdata=0xBEEF,
//   rdata_valid in cycle 2; busy high in cycles 0-1 only.
//  lb addr=0x0043, 3 wait states, rdata=0x12AB -> be=10, o_bus_addr=0x0043, o_rdata=0x0012.
//  sw addr=0x0100 wdata=0x5A5A -> we=1, be=11, wdata stable until ack; o_rdata keeps prior value.
//  lw addr=0x0041 -> no o_bus_req; o_err pulse in cycle 1, cause 01; busy high only in cycle 0.
//  TIMEOUT=4, no ack -> req drops after 4 REQ cycles, o_err with cause 11.
//   Also ack together with err -> cause 10.
//  i_rst during REQ -> req=0 next cycle, state IDLE, no rdata_valid/err pulse; next lw completes normally.

Source files
------------

// File: rtl/lsu_bus_ctrl.sv
// Load/store unit bus controller: issues one req/ack bus transaction per memory instruction,
// stalls execute while it is in flight and reports misalignment, bus errors and timeouts.
module lsu_bus_ctrl #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req_valid,
    input  logic          i_is_lw,
    input  logic          i_is_lb,
    input  logic          i_is_sw,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic          o_busy,
    output logic [DW-1:0] o_rdata,
    output logic          o_rdata_valid,
    output logic          o_err,
    output logic [1:0]    o_err_cause,
    output logic          o_bus_req,
    output logic          o_bus_we,
    output logic [AW-1:0] o_bus_addr,
    output logic [DW-1:0] o_bus_wdata,
    output logic [1:0]    o_bus_be,
    input  logic          i_bus_ack,
    input  logic [DW-1:0] i_bus_rdata,
    input  logic          i_bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } state_t;

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);
    localparam logic       TMO_EN    = (TIMEOUT != 0);

    localparam logic [1:0] CAUSE_ALIGN = 2'b01;
    localparam logic [1:0] CAUSE_BUS   = 2'b10;
    localparam logic [1:0] CAUSE_TMO   = 2'b11;

    state_t        state_r;
    logic [7:0]    tmo_cnt_r;
    logic          is_lb_r;
    logic          is_load_r;

    logic          decode_ok_s;
    logic          misalign_s;
    logic          reject_s;
    logic          tmo_hit_s;
    logic [1:0]    be_s;
    logic [AW-1:0] addr_s;

    function automatic logic onehot3(input logic a, input logic b, input logic c);
        return ({a, b, c} == 3'b100) || ({a, b, c} == 3'b010) || ({a, b, c} == 3'b001);
    endfunction

    // lb is zero-extended from the lane picked by the latched address bit 0
    function automatic logic [15:0] load_result(input logic is_lb, input logic hi_lane,
                                                input logic [15:0] bus_rdata);
        logic [15:0] res;
        if (!is_lb) begin
            res = bus_rdata;
        end else if (hi_lane) begin
            res = {8'h00, bus_rdata[15:8]};
        end else begin
            res = {8'h00, bus_rdata[7:0]};
        end
        return res;
    endfunction

    // Request decode: legality, alignment, byte enables and bus address for the incoming access
    always_comb begin
        decode_ok_s = onehot3(i_is_lw, i_is_lb, i_is_sw);
        misalign_s  = (i_is_lw || i_is_sw) && i_addr[0];
        reject_s    = !decode_ok_s || misalign_s;
        addr_s      = i_addr;
        if (i_is_lb) begin
            be_s = i_addr[0] ? 2'b10 : 2'b01;
        end else begin
            be_s      = 2'b11;
            addr_s[0] = 1'b0;
        end
    end

    // Timeout fires on the REQ cycle that would complete TIMEOUT cycles without an ack
    always_comb begin
        if (TMO_EN) begin
            tmo_hit_s = (tmo_cnt_r == (TMO_LIMIT - 8'd1));
        end else begin
            tmo_hit_s = 1'b0;
        end
    end

    // Stall execute while a request is being accepted or is in flight
    always_comb begin
        o_busy = ((state_r == ST_IDLE) && i_req_valid) || (state_r == ST_REQ);
    end

    // Access FSM with all bus and result outputs registered
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r       <= ST_IDLE;
            tmo_cnt_r     <= 8'd0;
            is_lb_r       <= 1'b0;
            is_load_r     <= 1'b0;
            o_rdata       <= '0;
            o_rdata_valid <= 1'b0;
            o_err         <= 1'b0;
            o_err_cause   <= 2'b00;
            o_bus_req     <= 1'b0;
            o_bus_we      <= 1'b0;
            o_bus_addr    <= '0;
            o_bus_wdata   <= '0;
            o_bus_be      <= 2'b00;
        end else begin
            o_rdata_valid <= 1'b0;
            o_err         <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        if (reject_s) begin
                            state_r     <= ST_ERR;
                            o_err       <= 1'b1;
                            o_err_cause <= CAUSE_ALIGN;
                        end else begin
                            state_r     <= ST_REQ;
                            tmo_cnt_r   <= 8'd0;
                            is_lb_r     <= i_is_lb;
                            is_load_r   <= i_is_lw || i_is_lb;
                            o_bus_req   <= 1'b1;
                            o_bus_we    <= i_is_sw;
                            o_bus_addr  <= addr_s;
                            o_bus_wdata <= i_wdata;
                            o_bus_be    <= be_s;
                        end
                    end
                end
                ST_REQ: begin
                    // Error beats ack; ack beats the timeout landing on the same cycle
                    if (i_bus_err) begin
                        state_r     <= ST_ERR;
                        o_bus_req   <= 1'b0;
                        o_err       <= 1'b1;
                        o_err_cause <= CAUSE_BUS;
                    end else if (i_bus_ack) begin
                        state_r       <= ST_DONE;
                        o_bus_req     <= 1'b0;
                        o_rdata_valid <= 1'b1;
                        if (is_load_r) begin
                            o_rdata <= load_result(is_lb_r, o_bus_addr[0], i_bus_rdata);
                        end
                    end else if (tmo_hit_s) begin
                        state_r     <= ST_ERR;
                        o_bus_req   <= 1'b0;
                        o_err       <= 1'b1;
                        o_err_cause <= CAUSE_TMO;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 8'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                ST_ERR: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    o_bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed bench for lsu_bus_ctrl: inputs change 1 ns after the rising edge, outputs are checked
// on the falling edge. Built with TIMEOUT=4 so the timeout path is reachable in a few cycles.
module tb_lsu_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        is_lw;
    logic        is_lb;
    logic        is_sw;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        busy;
    logic [15:0] rdata;
    logic        rdata_valid;
    logic        err;
    logic [1:0]  err_cause;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic [1:0]  bus_be;
    logic        bus_ack;
    logic [15:0] bus_rdata;
    logic        bus_err;

    int vectors   = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lsu_bus_ctrl #(.AW(16), .DW(16), .TIMEOUT(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .i_is_lw(is_lw), .i_is_lb(is_lb), .i_is_sw(is_sw),
        .i_addr(addr), .i_wdata(wdata),
        .o_busy(busy), .o_rdata(rdata), .o_rdata_valid(rdata_valid),
        .o_err(err), .o_err_cause(err_cause),
        .o_bus_req(bus_req), .o_bus_we(bus_we), .o_bus_addr(bus_addr),
        .o_bus_wdata(bus_wdata), .o_bus_be(bus_be),
        .i_bus_ack(bus_ack), .i_bus_rdata(bus_rdata), .i_bus_err(bus_err)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0; is_lw = 1'b0; is_lb = 1'b0; is_sw = 1'b0;
        addr = 16'h0000; wdata = 16'h0000;
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 16'h0000;
    endtask

    task automatic issue(input logic lw, input logic lb, input logic sw,
                         input logic [15:0] a, input logic [15:0] d);
        req_valid = 1'b1; is_lw = lw; is_lb = lb; is_sw = sw; addr = a; wdata = d;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        cyc();
        cyc();
        smp();
        check_vec("rst.req",   32'(bus_req),     32'd0);
        check_vec("rst.we",    32'(bus_we),      32'd0);
        check_vec("rst.be",    32'(bus_be),      32'd0);
        check_vec("rst.addr",  32'(bus_addr),    32'h0);
        check_vec("rst.rdata", 32'(rdata),       32'h0);
        check_vec("rst.rv",    32'(rdata_valid), 32'd0);
        check_vec("rst.err",   32'(err),         32'd0);
        check_vec("rst.cause", 32'(err_cause),   32'd0);
        cyc(); rst = 1'b0;

        // lw 0x0040, ack in cycle 1
        cyc(); issue(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000); smp();
        check_vec("lw.c0.busy", 32'(busy), 32'd1);
        check_vec("lw.c0.req",  32'(bus_req), 32'd0);
        cyc(); bus_ack = 1'b1; bus_rdata = 16'hBEEF; smp();
        check_vec("lw.c1.req",  32'(bus_req), 32'd1);
        check_vec("lw.c1.be",   32'(bus_be), 32'd3);
        check_vec("lw.c1.we",   32'(bus_we), 32'd0);
        check_vec("lw.c1.addr", 32'(bus_addr), 32'h0040);
        check_vec("lw.c1.busy", 32'(busy), 32'd1);
        cyc(); bus_ack = 1'b0; bus_rdata = 16'h0000; smp();
        check_vec("lw.c2.rv",    32'(rdata_valid), 32'd1);
        check_vec("lw.c2.rdata", 32'(rdata), 32'hBEEF);
        check_vec("lw.c2.busy",  32'(busy), 32'd0);
        check_vec("lw.c2.req",   32'(bus_req), 32'd0);
        cyc(); idle_inputs(); smp();
        check_vec("lw.c3.rv", 32'(rdata_valid), 32'd0);

        // lb 0x0043, three wait states, upper lane
        cyc(); issue(1'b0, 1'b1, 1'b0, 16'h0043, 16'h0000); smp();
        check_vec("lb.c0.busy", 32'(busy), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            cyc(); smp();
            check_vec("lb.wait.req",  32'(bus_req), 32'd1);
            check_vec("lb.wait.be",   32'(bus_be), 32'd2);
            check_vec("lb.wait.addr", 32'(bus_addr), 32'h0043);
            check_vec("lb.wait.busy", 32'(busy), 32'd1);
        end
        cyc(); bus_ack = 1'b1; bus_rdata = 16'h12AB; smp();
        check_vec("lb.c4.req", 32'(bus_req), 32'd1);
        cyc(); bus_ack = 1'b0; smp();
        check_vec("lb.c5.rv",    32'(rdata_valid), 32'd1);
        check_vec("lb.c5.rdata", 32'(rdata), 32'h0012);
        check_vec("lb.c5.err",   32'(err), 32'd0);
        cyc(); idle_inputs();

        // sw 0x0100 / 0x5A5A, ack in cycle 2
        cyc(); issue(1'b0, 1'b0, 1'b1, 16'h0100, 16'h5A5A); smp();
        cyc(); smp();
        check_vec("sw.c1.we",    32'(bus_we), 32'd1);
        check_vec("sw.c1.be",    32'(bus_be), 32'd3);
        check_vec("sw.c1.wdata", 32'(bus_wdata), 32'h5A5A);
        check_vec("sw.c1.addr",  32'(bus_addr), 32'h0100);
        cyc(); bus_ack = 1'b1; bus_rdata = 16'hFFFF; smp();
        check_vec("sw.c2.wdata", 32'(bus_wdata), 32'h5A5A);
        check_vec("sw.c2.req",   32'(bus_req), 32'd1);
        cyc(); bus_ack = 1'b0; smp();
        check_vec("sw.c3.rv",    32'(rdata_valid), 32'd1);
        check_vec("sw.c3.rdata", 32'(rdata), 32'h0012);
        cyc(); idle_inputs();

        // misaligned lw 0x0041
        cyc(); issue(1'b1, 1'b0, 1'b0, 16'h0041, 16'h0000); smp();
        check_vec("mis.c0.busy", 32'(busy), 32'd1);
        cyc(); smp();
        check_vec("mis.c1.req",   32'(bus_req), 32'd0);
        check_vec("mis.c1.err",   32'(err), 32'd1);
        check_vec("mis.c1.cause", 32'(err_cause), 32'd1);
        check_vec("mis.c1.busy",  32'(busy), 32'd0);
        cyc(); idle_inputs(); smp();
        check_vec("mis.c2.err", 32'(err), 32'd0);

        // timeout: lw 0x0200, no ack, TIMEOUT=4
        cyc(); issue(1'b1, 1'b0, 1'b0, 16'h0200, 16'h0000); smp();
        for (int i = 1; i <= 4; i++) begin
            cyc(); smp();
            check_vec("tmo.req", 32'(bus_req), 32'd1);
        end
        cyc(); smp();
        check_vec("tmo.c5.req",   32'(bus_req), 32'd0);
        check_vec("tmo.c5.err",   32'(err), 32'd1);
        check_vec("tmo.c5.cause", 32'(err_cause), 32'd3);
        check_vec("tmo.c5.rdata", 32'(rdata), 32'h0012);
        cyc(); idle_inputs();

        // ack together with err: error wins
        cyc(); issue(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000); smp();
        cyc(); bus_ack = 1'b1; bus_err = 1'b1; bus_rdata = 16'h7777; smp();
        cyc(); bus_ack = 1'b0; bus_err = 1'b0; smp();
        check_vec("ae.err",   32'(err), 32'd1);
        check_vec("ae.cause", 32'(err_cause), 32'd2);
        check_vec("ae.rv",    32'(rdata_valid), 32'd0);
        check_vec("ae.rdata", 32'(rdata), 32'h0012);
        cyc(); idle_inputs();

        // illegal decode: lw and sw together
        cyc(); issue(1'b1, 1'b0, 1'b1, 16'h0020, 16'h0000); smp();
        cyc(); smp();
        check_vec("ill.req",   32'(bus_req), 32'd0);
        check_vec("ill.err",   32'(err), 32'd1);
        check_vec("ill.cause", 32'(err_cause), 32'd1);
        cyc(); idle_inputs();

        // lb 0x0044, lower lane
        cyc(); issue(1'b0, 1'b1, 1'b0, 16'h0044, 16'h0000); smp();
        cyc(); bus_ack = 1'b1; bus_rdata = 16'h34CD; smp();
        check_vec("lb0.be", 32'(bus_be), 32'd1);
        cyc(); bus_ack = 1'b0; smp();
        check_vec("lb0.rdata", 32'(rdata), 32'h00CD);
        cyc(); idle_inputs();

        // stray ack/err in IDLE are ignored
        cyc(); bus_ack = 1'b1; bus_err = 1'b1; smp();
        cyc(); bus_ack = 1'b0; bus_err = 1'b0; smp();
        check_vec("stray.err", 32'(err), 32'd0);
        check_vec("stray.rv",  32'(rdata_valid), 32'd0);

        // reset during REQ, then a normal lw
        cyc(); issue(1'b1, 1'b0, 1'b0, 16'h0060, 16'h0000); smp();
        cyc(); rst = 1'b1; smp();
        check_vec("rreq.c1.req", 32'(bus_req), 32'd1);
        cyc(); rst = 1'b0; idle_inputs(); smp();
        check_vec("rreq.c2.req",  32'(bus_req), 32'd0);
        check_vec("rreq.c2.rv",   32'(rdata_valid), 32'd0);
        check_vec("rreq.c2.err",  32'(err), 32'd0);
        check_vec("rreq.c2.busy", 32'(busy), 32'd0);
        check_vec("rreq.c2.addr", 32'(bus_addr), 32'h0);
        cyc(); issue(1'b1, 1'b0, 1'b0, 16'h0080, 16'h0000); smp();
        cyc(); bus_ack = 1'b1; bus_rdata = 16'h1357; smp();
        check_vec("rreq.lw.addr", 32'(bus_addr), 32'h0080);
        cyc(); bus_ack = 1'b0; smp();
        check_vec("rreq.lw.rv",    32'(rdata_valid), 32'd1);
        check_vec("rreq.lw.rdata", 32'(rdata), 32'h1357);
        cyc(); idle_inputs();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
